// File: rtl/execute_stage.sv
// execute_stage: execute stage of the 5-stage pipeline, feeding the memory
// access stage from a registered EX/MEM output register.
// Single-cycle ALU for ops 0-9; ops 13-15 are illegal (result 0, illegal_op=1).
// Optional feature macro MULDIV_EN: when defined, ops 10-12 (MUL/DIVU/REMU)
// run on a 32-iteration shift-add / restoring-divide engine and stall the
// upstream stage via in_ready. When undefined, ops 10-12 are illegal too and
// in_ready is tied high.
module execute_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                op,
    input  logic [DATA_WIDTH-1:0]     operand_a,
    input  logic [DATA_WIDTH-1:0]     operand_b,
    input  logic [DATA_WIDTH-1:0]     store_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic                      reg_write_in,
    input  logic                      mem_write_in,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     alu_result,
    output logic [ADDR_WIDTH-1:0]     address,
    output logic [DATA_WIDTH-1:0]     store_data,
    output logic                      write,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      reg_write_out,
    output logic                      illegal_op
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    // Single-cycle ALU: returns {illegal, result}. Ops 10-15 fall into the
    // illegal default; the iterative engine supplies 10-12 when present.
    function automatic logic [DATA_WIDTH:0] f_alu(
        input logic [3:0]            f_op,
        input logic [DATA_WIDTH-1:0] f_a,
        input logic [DATA_WIDTH-1:0] f_b
    );
        logic [DATA_WIDTH-1:0] v_res;
        logic                  v_ill;
        v_res = '0;
        v_ill = 1'b0;
        case (f_op)
            OP_ADD:  v_res = f_a + f_b;
            OP_SUB:  v_res = f_a - f_b;
            OP_AND:  v_res = f_a & f_b;
            OP_OR:   v_res = f_a | f_b;
            OP_XOR:  v_res = f_a ^ f_b;
            OP_SLL:  v_res = f_a << f_b[SHW-1:0];
            OP_SRL:  v_res = f_a >> f_b[SHW-1:0];
            OP_SRA:  v_res = $unsigned($signed(f_a) >>> f_b[SHW-1:0]);
            OP_SLT:  v_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(f_a) < $signed(f_b))};
            OP_SLTU: v_res = {{(DATA_WIDTH-1){1'b0}}, (f_a < f_b)};
            default: begin
                v_res = '0;
                v_ill = 1'b1;
            end
        endcase
        return {v_ill, v_res};
    endfunction

    logic                      w_accept;
    logic                      w_start_md;
    logic                      w_md_done;
    logic [DATA_WIDTH-1:0]     w_md_result;
    logic [DATA_WIDTH-1:0]     w_md_store;
    logic [REG_ADDR_WIDTH-1:0] w_md_rd;
    logic                      w_md_regw;
    logic                      w_md_memw;
    logic [DATA_WIDTH:0]       w_alu;

    assign w_accept = in_valid && in_ready;
    assign w_alu    = f_alu(op, operand_a, operand_b);

`ifdef MULDIV_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]                r_state;
    logic [SHW-1:0]            r_count;
    // r_x: multiplier (MUL) or dividend/quotient (DIV)
    // r_y: multiplicand (MUL) or divisor (DIV)
    // r_acc: partial product (MUL) or partial remainder (DIV)
    logic [DATA_WIDTH-1:0]     r_x;
    logic [DATA_WIDTH-1:0]     r_y;
    logic [DATA_WIDTH-1:0]     r_acc;
    logic                      r_is_rem;
    logic [DATA_WIDTH-1:0]     r_store_lat;
    logic [REG_ADDR_WIDTH-1:0] r_rd_lat;
    logic                      r_regw_lat;
    logic                      r_memw_lat;

    logic [DATA_WIDTH:0]       w_shifted;
    logic [DATA_WIDTH:0]       w_diff;
    logic [DATA_WIDTH-1:0]     w_x_nxt;
    logic [DATA_WIDTH-1:0]     w_y_nxt;
    logic [DATA_WIDTH-1:0]     w_acc_nxt;
    logic                      w_last;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_start_md  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    assign w_last      = (r_count == SHW'(DATA_WIDTH - 1));
    assign w_md_done   = (r_state != ST_IDLE) && w_last;
    assign w_md_store  = r_store_lat;
    assign w_md_rd     = r_rd_lat;
    assign w_md_regw   = r_regw_lat;
    assign w_md_memw   = r_memw_lat;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        w_shifted = {r_acc, r_x[DATA_WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_y};
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        w_acc_nxt = r_acc;
        if (r_state == ST_MUL) begin
            w_acc_nxt = r_acc + (r_x[0] ? r_y : '0);
            w_x_nxt   = r_x >> 1;
            w_y_nxt   = r_y << 1;
        end else begin
            // Negative trial difference (bit DATA_WIDTH set) restores.
            w_x_nxt   = {r_x[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
            w_acc_nxt = w_diff[DATA_WIDTH] ? w_shifted[DATA_WIDTH-1:0]
                                           : w_diff[DATA_WIDTH-1:0];
        end
        w_md_result = ((r_state == ST_DIV) && !r_is_rem) ? w_x_nxt : w_acc_nxt;
    end

    // FSM and iteration counter; reset aborts any running operation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept && w_start_md) begin
                r_state <= (op == OP_MUL) ? ST_MUL : ST_DIV;
                r_count <= '0;
            end
        end else if (w_last) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Iterative datapath: latch operands and sideband at accept, then step.
    always_ff @(posedge clock) begin
        if (r_state == ST_IDLE) begin
            if (w_accept && w_start_md) begin
                r_x         <= (op == OP_MUL) ? operand_b : operand_a;
                r_y         <= (op == OP_MUL) ? operand_a : operand_b;
                r_acc       <= '0;
                r_is_rem    <= (op == OP_REMU);
                r_store_lat <= store_data_in;
                r_rd_lat    <= rd_in;
                r_regw_lat  <= reg_write_in;
                r_memw_lat  <= mem_write_in;
            end
        end else begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_acc <= w_acc_nxt;
        end
    end
`else
    assign in_ready    = 1'b1;
    assign w_start_md  = 1'b0;
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
    assign w_md_store  = '0;
    assign w_md_rd     = '0;
    assign w_md_regw   = 1'b0;
    assign w_md_memw   = 1'b0;
`endif

    // ---- EX/MEM output register (stage p1) ----
    logic                      r_vld_p1;
    logic [DATA_WIDTH-1:0]     r_result_p1;
    logic [DATA_WIDTH-1:0]     r_store_p1;
    logic                      r_write_p1;
    logic [REG_ADDR_WIDTH-1:0] r_rd_p1;
    logic                      r_regw_p1;
    logic                      r_illegal_p1;

    // Load iterative result, or single-cycle result, else insert a bubble.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_vld_p1     <= 1'b0;
            r_result_p1  <= '0;
            r_store_p1   <= '0;
            r_write_p1   <= 1'b0;
            r_rd_p1      <= '0;
            r_regw_p1    <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else if (w_md_done) begin
            r_vld_p1     <= 1'b1;
            r_result_p1  <= w_md_result;
            r_store_p1   <= w_md_store;
            r_write_p1   <= w_md_memw;
            r_rd_p1      <= w_md_rd;
            r_regw_p1    <= w_md_regw;
            r_illegal_p1 <= 1'b0;
        end else if (w_accept && !w_start_md) begin
            r_vld_p1     <= 1'b1;
            r_result_p1  <= w_alu[DATA_WIDTH-1:0];
            r_store_p1   <= store_data_in;
            r_write_p1   <= mem_write_in;
            r_rd_p1      <= rd_in;
            r_regw_p1    <= reg_write_in;
            r_illegal_p1 <= w_alu[DATA_WIDTH];
        end else begin
            r_vld_p1   <= 1'b0;
            r_write_p1 <= 1'b0;
            r_regw_p1  <= 1'b0;
        end
    end

    assign out_valid     = r_vld_p1;
    assign alu_result    = r_result_p1;
    assign address       = r_result_p1[ADDR_WIDTH-1:0];
    assign store_data    = r_store_p1;
    assign write         = r_write_p1;
    assign rd_out        = r_rd_p1;
    assign reg_write_out = r_regw_p1;
    assign illegal_op    = r_illegal_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage (default build and MULDIV_EN build).
module tb_execute_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_write_in;
    logic        out_valid;
    logic [31:0] alu_result;
    logic [10:0] address;
    logic [31:0] store_data;
    logic        write;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    execute_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .store_data_in(store_data_in), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
        .out_valid(out_valid), .alu_result(alu_result), .address(address),
        .store_data(store_data), .write(write), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .illegal_op(illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge so inputs are stable around the rising edge.
    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mw);
        @(negedge clock);
        in_valid = v; op = o; operand_a = a; operand_b = b;
        store_data_in = sd; rd_in = rd; reg_write_in = rw; mem_write_in = mw;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-cycle op: one edge, then check result and illegal flag.
    task automatic alu1(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic ill);
        drive(1'b1, o, a, b, 32'h0, 5'd1, 1'b1, 1'b0);
        tick();
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, alu_result, exp);
        chk({tag, "_ill"}, {31'd0, illegal_op}, {31'd0, ill});
    endtask

`ifdef MULDIV_EN
    // Multi-cycle op: count edges after the accept until out_valid, bounded.
    task automatic md(input string tag, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        int n;
        drive(1'b1, o, a, b, 32'h0, 5'd4, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 32);
        chk({tag, "_res"}, alu_result, exp);
    endtask
`endif

    initial begin
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_res", alu_result, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_wr", {31'd0, write}, 32'd0);
        chk("rst_rw", {31'd0, reg_write_out}, 32'd0);
        chk("rst_ill", {31'd0, illegal_op}, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_sd", store_data, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // ADD 5+7 -> rd 3
        drive(1'b1, 4'd0, 32'd5, 32'd7, 32'h0, 5'd3, 1'b1, 1'b0);
        tick();
        chk("add_vld", {31'd0, out_valid}, 32'd1);
        chk("add_res", alu_result, 32'd12);
        chk("add_rd", {27'd0, rd_out}, 32'd3);
        chk("add_rw", {31'd0, reg_write_out}, 32'd1);
        chk("add_wr", {31'd0, write}, 32'd0);

        // Store: address is low 11 bits of the sum
        drive(1'b1, 4'd0, 32'h100, 32'h7FF, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1);
        tick();
        chk("st_res", alu_result, 32'h8FF);
        chk("st_addr", {21'd0, address}, 32'h0FF);
        chk("st_sd", store_data, 32'hDEADBEEF);
        chk("st_wr", {31'd0, write}, 32'd1);

        // Bubble: strobes drop, data holds
        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("bub_vld", {31'd0, out_valid}, 32'd0);
        chk("bub_wr", {31'd0, write}, 32'd0);
        chk("bub_rw", {31'd0, reg_write_out}, 32'd0);
        chk("bub_hold", alu_result, 32'h8FF);

        alu1("sra", 4'd7, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
        alu1("slt", 4'd8, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        alu1("sltu", 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        alu1("sub", 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
        alu1("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        alu1("or", 4'd3, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101, 1'b0);
        alu1("xor", 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
        alu1("sll", 4'd5, 32'd1, 32'd31, 32'h80000000, 1'b0);
        alu1("srl", 4'd6, 32'h80000000, 32'h24, 32'h08000000, 1'b0);
        alu1("ill14", 4'd14, 32'd5, 32'd6, 32'd0, 1'b1);
        alu1("add_after_ill", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0);

`ifdef MULDIV_EN
        // MUL with a held follow-on ADD during the busy window
        drive(1'b1, 4'd10, 32'h10000, 32'h10001, 32'h0, 5'd9, 1'b1, 1'b0);
        tick();
        chk("mul_rdy0", {31'd0, in_ready}, 32'd0);
        chk("mul_vld0", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 4'd0, 32'd1, 32'd2, 32'h0, 5'd7, 1'b1, 1'b0);
        for (int i = 1; i < 32; i++) begin
            tick();
            chk("mul_busy", {30'd0, in_ready, out_valid}, 32'd0);
        end
        tick();
        chk("mul_vld", {31'd0, out_valid}, 32'd1);
        chk("mul_res", alu_result, 32'h00010000);
        chk("mul_rd", {27'd0, rd_out}, 32'd9);
        chk("mul_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("held_vld", {31'd0, out_valid}, 32'd1);
        chk("held_res", alu_result, 32'd3);
        chk("held_rd", {27'd0, rd_out}, 32'd7);

        md("divu", 4'd11, 32'd100, 32'd7, 32'd14);
        md("remu", 4'd12, 32'd100, 32'd7, 32'd2);
        md("divu0", 4'd11, 32'd5, 32'd0, 32'hFFFFFFFF);
        md("remu0", 4'd12, 32'd5, 32'd0, 32'd5);
        md("mulbig", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Reset at E10 of a DIVU aborts it
        drive(1'b1, 4'd11, 32'd1000, 32'd3, 32'h0, 5'd2, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 1; i < 9; i++) tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("abort_vld", {31'd0, out_valid}, 32'd0);
        chk("abort_rdy", {31'd0, in_ready}, 32'd1);
        chk("abort_res", alu_result, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("abort_novld", seen, 32'd0);
        end
        alu1("ill14b", 4'd14, 32'd9, 32'd9, 32'd0, 1'b1);
`else
        alu1("mul_ill", 4'd10, 32'h10000, 32'h10001, 32'd0, 1'b1);
        chk("mul_rdy", {31'd0, in_ready}, 32'd1);
        alu1("divu_ill", 4'd11, 32'd100, 32'd7, 32'd0, 1'b1);
        alu1("remu_ill", 4'd12, 32'd100, 32'd7, 32'd0, 1'b1);
        chk("md_rdy", {31'd0, in_ready}, 32'd1);
`endif

        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
